// File: rtl/uart_boot_loader_ctrl_if.sv
// Byte-stream and memory-write bundle between uart_rx, the boot loader and the instruction memory.
// master = the boot loader controller; slave = the environment (uart_rx + memory).
`timescale 1ns/1ps
interface uart_boot_loader_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        i_rx_data;
    logic              i_rx_dv;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              i_mem_ready;

    modport master (
        input  i_rx_data, i_rx_dv, i_mem_ready,
        output o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport slave (
        output i_rx_data, i_rx_dv, i_mem_ready,
        input  o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/uart_boot_loader_ctrl.sv
// Framed-command boot loader: parses SYNC/CMD/ADDR/LEN/DATA/CSUM frames from uart_rx,
// writes 32-bit words into instruction memory and holds the core in reset while loading.
`timescale 1ns/1ps
module uart_boot_loader_ctrl #(
    parameter int          ADDR_W        = 16,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int          TIMEOUT_CLKS  = 8680,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_boot_loader_ctrl_if.master bus,
    output logic                    o_cpu_hold,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [1:0]              o_err_code
);

    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_PROTO   = 2'd3;

    typedef enum logic [2:0] {
        ST_HDR, ST_CMD, ST_ALO, ST_AHI, ST_LEN, ST_DATA, ST_WR, ST_CSUM
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_RUN   = 2'd2,
        CMD_HALT  = 2'd3
    } cmd_e;

    state_e            state_q,    state_d;
    cmd_e              cmd_q,      cmd_d;
    logic [7:0]        addr_lo_q,  addr_lo_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [23:0]       shift_q,    shift_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        words_q,    words_d;
    logic [7:0]        sum_q,      sum_d;
    logic [TMO_W-1:0]  tmo_q,      tmo_d;
    logic              we_q,       we_d;
    logic              hold_q,     hold_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              rx_dv;
    logic [7:0]        rx_data;
    logic [7:0]        sum_next;
    logic              tmo_counting;
    logic              tmo_hit;

    assign rx_dv    = bus.i_rx_dv;
    assign rx_data  = bus.i_rx_data;
    assign sum_next = sum_q + rx_data;

    // The idle timer only runs while waiting for the next byte of a frame.
    assign tmo_counting = (state_q != ST_HDR) && (state_q != ST_WR);
    assign tmo_hit      = tmo_counting && !rx_dv && (tmo_q == TMO_LAST);

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_lo_d  = addr_lo_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        words_d    = words_q;
        sum_d      = sum_q;
        we_d       = we_q;
        hold_d     = hold_q;
        err_code_d = err_code_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tmo_d      = (rx_dv || !tmo_counting) ? '0 : tmo_q + TMO_W'(1);

        if (tmo_hit) begin
            we_d       = 1'b0;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = ST_HDR;
        end else begin
            unique case (state_q)
                ST_HDR: begin
                    if (rx_dv && rx_data == SYNC_BYTE) begin
                        sum_d   = '0;
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (rx_dv) begin
                        sum_d = sum_next;
                        if (rx_data == 8'h01 || rx_data == 8'h02 || rx_data == 8'h03) begin
                            cmd_d   = cmd_e'(rx_data[1:0]);
                            state_d = ST_ALO;
                            // A WRITE freezes the core as soon as it is recognised.
                            if (rx_data == 8'h01) hold_d = 1'b1;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_PROTO;
                            state_d    = ST_HDR;
                        end
                    end
                end
                ST_ALO: begin
                    if (rx_dv) begin
                        sum_d     = sum_next;
                        addr_lo_d = rx_data;
                        state_d   = ST_AHI;
                    end
                end
                ST_AHI: begin
                    if (rx_dv) begin
                        sum_d   = sum_next;
                        addr_d  = ADDR_W'({rx_data, addr_lo_q});
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (rx_dv) begin
                        sum_d      = sum_next;
                        words_d    = rx_data;
                        byte_idx_d = '0;
                        state_d    = (cmd_q == CMD_WRITE && rx_data != 8'd0) ? ST_DATA : ST_CSUM;
                    end
                end
                ST_DATA: begin
                    if (rx_dv) begin
                        sum_d      = sum_next;
                        shift_d    = {rx_data, shift_q[23:8]};
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            wdata_d = {rx_data, shift_q};
                            we_d    = 1'b1;
                            state_d = ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    // A byte arriving before the write retires means data would be lost.
                    if (rx_dv) begin
                        we_d       = 1'b0;
                        err_d      = 1'b1;
                        err_code_d = ERR_PROTO;
                        state_d    = ST_HDR;
                    end else if (bus.i_mem_ready) begin
                        we_d    = 1'b0;
                        addr_d  = addr_q + ADDR_W'(1);
                        words_d = words_q - 8'd1;
                        state_d = (words_q == 8'd1) ? ST_CSUM : ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (rx_dv) begin
                        state_d = ST_HDR;
                        if (sum_next == 8'd0) begin
                            done_d = 1'b1;
                            if (cmd_q == CMD_RUN)  hold_d = 1'b0;
                            if (cmd_q == CMD_HALT) hold_d = 1'b1;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_CSUM;
                        end
                    end
                end
                default: state_d = ST_HDR;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_HDR;
            cmd_q      <= CMD_NONE;
            addr_lo_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            shift_q    <= '0;
            byte_idx_q <= '0;
            words_q    <= '0;
            sum_q      <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            hold_q     <= HOLD_AT_RESET;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_lo_q  <= addr_lo_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            words_q    <= words_d;
            sum_q      <= sum_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.o_mem_we    = we_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign o_cpu_hold      = hold_q;
    assign o_busy          = (state_q != ST_HDR);
    assign o_done          = done_q;
    assign o_err           = err_q;
    assign o_err_code      = err_code_q;

endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// Self-checking bench for uart_boot_loader_ctrl: frames are built and their outcomes
// predicted from the frame rules, then compared against a write monitor and pulse counters.
`timescale 1ns/1ps
module tb_uart_boot_loader_ctrl;

    localparam int ADDR_W = 16;
    localparam int TMO    = 8680;
    localparam int GAP    = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_hold, busy, done, err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    uart_boot_loader_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    uart_boot_loader_ctrl #(
        .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO), .HOLD_AT_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_cpu_hold(cpu_hold), .o_busy(busy), .o_done(done),
        .o_err(err), .o_err_code(err_code)
    );

    int n_pass  = 0;
    int n_total = 0;

    int         n_done, n_err;
    logic [1:0] last_code;
    bit         we_seen, both_seen;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [31:0]       words[$];
    logic              exp_hold;
    bit                ready_en;
    int                stall;

    // Memory responder: accepts within at most four cycles unless disabled.
    always @(posedge clk) begin
        #1;
        if (!ready_en || !bus.o_mem_we) begin
            bus.i_mem_ready = 1'b0;
            if (!bus.o_mem_we) stall = 0;
        end else begin
            bus.i_mem_ready = (stall >= 3) || ($urandom_range(0, 2) == 0);
            stall = bus.i_mem_ready ? 0 : stall + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (done) n_done++;
            if (err) begin
                n_err++;
                last_code = err_code;
            end
            if (done && err) both_seen = 1'b1;
            if (bus.o_mem_we) we_seen = 1'b1;
            if (bus.o_mem_we && bus.i_mem_ready) begin
                wr_addr_q.push_back(bus.o_mem_addr);
                wr_data_q.push_back(bus.o_mem_wdata);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, required finish before 2ms");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data = b;
        bus.i_rx_dv   = 1'b1;
        @(negedge clk);
        bus.i_rx_dv   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        strobe(b);
        idle(GAP);
    endtask

    task automatic clear_mon();
        n_done    = 0;
        n_err     = 0;
        we_seen   = 1'b0;
        both_seen = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    bus.o_mem_we, 1'b0);
        check({tag, "_addr"},  bus.o_mem_addr, '0);
        check({tag, "_wdata"}, bus.o_mem_wdata, '0);
        check({tag, "_hold"},  cpu_hold, 1'b1);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_done"},  done, 1'b0);
        check({tag, "_err"},   err, 1'b0);
        check({tag, "_code"},  err_code, 2'd0);
    endtask

    // Sends a whole frame; the expected outcome follows from cmd, words and csum_off alone.
    task automatic send_frame(input string tag, input logic [7:0] cmd,
                              input logic [15:0] addr, input int csum_off);
        logic [7:0]  sum, csum, len;
        logic [15:0] ea;
        logic [31:0] w;
        bit          ok;
        int          n;
        clear_mon();
        n   = (cmd == 8'h01) ? words.size() : 0;
        len = 8'(n);
        send(8'hA5);
        send(cmd);
        if (!(cmd inside {8'h01, 8'h02, 8'h03})) begin
            check({tag, "_nerr"},  n_err, 1);
            check({tag, "_code"},  last_code, 2'd3);
            check({tag, "_ndone"}, n_done, 0);
            check({tag, "_busy"},  busy, 1'b0);
            return;
        end
        if (cmd == 8'h01) exp_hold = 1'b1;
        sum = cmd + addr[7:0] + addr[15:8] + len;
        send(addr[7:0]);
        send(addr[15:8]);
        send(len);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int b = 0; b < 4; b++) begin
                sum = sum + w[8*b +: 8];
                strobe(w[8*b +: 8]);
                if (b == 3) begin
                    ea = addr + 16'(i);
                    check($sformatf("%s_we%0d", tag, i),    bus.o_mem_we, 1'b1);
                    check($sformatf("%s_wdat%0d", tag, i),  bus.o_mem_wdata, w);
                    check($sformatf("%s_waddr%0d", tag, i), bus.o_mem_addr, ea);
                end
                idle(GAP);
            end
        end
        ok   = (csum_off == 0);
        csum = (8'd0 - sum) + 8'(csum_off);
        strobe(csum);
        if (ok && cmd == 8'h02) exp_hold = 1'b0;
        if (ok && cmd == 8'h03) exp_hold = 1'b1;
        check({tag, "_done_now"}, done, ok);
        check({tag, "_err_now"},  err, !ok);
        check({tag, "_hold"},     cpu_hold, exp_hold);
        idle(GAP);
        check({tag, "_ndone"}, n_done, ok ? 1 : 0);
        check({tag, "_nerr"},  n_err, ok ? 0 : 1);
        if (!ok) check({tag, "_code"}, last_code, 2'd1);
        check({tag, "_both"},  both_seen, 1'b0);
        check({tag, "_nwr"},   wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            ea = addr + 16'(i);
            check($sformatf("%s_mem_addr%0d", tag, i), wr_addr_q[i], ea);
            check($sformatf("%s_mem_data%0d", tag, i), wr_data_q[i], words[i]);
        end
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom());
    endtask

    initial begin
        rst             = 1'b0;
        bus.i_rx_dv     = 1'b0;
        bus.i_rx_data   = 8'h00;
        ready_en        = 1'b1;
        stall           = 0;
        exp_hold        = 1'b1;
        clear_mon();
        idle(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        idle(2);

        // Directed WRITE of two known instructions.
        words = '{32'h8B020020, 32'hD503201F};
        send_frame("t1_write", 8'h01, 16'h0010, 0);

        // RUN / bad-checksum HALT / HALT / RUN sequence.
        words.delete();
        send_frame("t2_run", 8'h02, 16'h0000, 0);
        send_frame("t2_halt_bad", 8'h03, 16'h0000, 1);
        send_frame("t2_halt", 8'h03, 16'h0000, 0);
        send_frame("t2_run2", 8'h02, 16'h0000, 0);

        // Bad checksum WRITE: words still land, hold set from CMD.
        words = '{32'h8B020020, 32'hD503201F};
        send_frame("t3_badsum", 8'h01, 16'h0010, 1);

        for (int k = 0; k < 3; k++) begin
            rand_words($urandom_range(1, 3));
            send_frame($sformatf("rnd%0d", k), 8'h01, 16'($urandom()), 0);
        end
        words.delete();
        send_frame("t3_write_len0", 8'h01, 16'h0200, 0);

        // Idle stall mid-word trips the timeout.
        clear_mon();
        send(8'hA5); send(8'h01); send(8'h40); send(8'h00); send(8'h01);
        send(8'h11); send(8'h22);
        idle(TMO + 100);
        check("t4_nerr",  n_err, 1);
        check("t4_code",  last_code, 2'd2);
        check("t4_we",    we_seen, 1'b0);
        check("t4_busy",  busy, 1'b0);
        check("t4_ndone", n_done, 0);
        check("t4_hold",  cpu_hold, 1'b1);
        rand_words(1);
        send_frame("t4_after", 8'h01, 16'h0040, 0);

        // Byte arriving while memory stalls is an overrun.
        ready_en = 1'b0;
        clear_mon();
        send(8'hA5); send(8'h01); send(8'h20); send(8'h00); send(8'h02);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(1500);
        check("t5_we_held",   bus.o_mem_we, 1'b1);
        check("t5_busy_wr",   busy, 1'b1);
        strobe(8'h05);
        check("t5_err_now",   err, 1'b1);
        check("t5_we_drop",   bus.o_mem_we, 1'b0);
        idle(GAP);
        check("t5_nerr",  n_err, 1);
        check("t5_code",  last_code, 2'd3);
        check("t5_nwr",   wr_addr_q.size(), 0);
        check("t5_busy",  busy, 1'b0);
        ready_en = 1'b1;
        send_frame("t5_badcmd", 8'h07, 16'h0000, 0);
        clear_mon();
        send(8'h00); send(8'hFF);
        check("t5_garbage_busy", busy, 1'b0);
        check("t5_garbage_err",  n_err, 0);
        words.delete();
        send_frame("t5_after_garbage", 8'h02, 16'h0000, 0);

        // Asynchronous reset mid-DATA.
        clear_mon();
        send(8'hA5); send(8'h01); send(8'h34); send(8'h12); send(8'h01);
        send(8'hAA); send(8'hBB);
        #2 rst = 1'b0;
        #1 check_reset_outputs("t6_rst_data");
        exp_hold = 1'b1;
        @(negedge clk) rst = 1'b1;
        idle(2);

        // Asynchronous reset with a write pending.
        ready_en = 1'b0;
        clear_mon();
        send(8'hA5); send(8'h01); send(8'h34); send(8'h12); send(8'h01);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("t6_we_pending", bus.o_mem_we, 1'b1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("t6_rst_wr");
        @(negedge clk) rst = 1'b1;
        ready_en = 1'b1;
        idle(20);
        check("t6_no_write", wr_addr_q.size(), 0);

        // Address wraps from the top of the word space to zero.
        rand_words(2);
        send_frame("t6_wrap", 8'h01, 16'hFFFF, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
